// File: rtl/psychic5_sdram_arbiter.sv
// Two-port ROM fetch arbiter: one-word cache per port (main CPU, object ROM),
// misses arbitrated round-robin onto a single 16-bit SDRAM read channel.
module psychic5_sdram_arbiter #(
    parameter logic [21:0] MAINCPU_BASE = 22'h000000,
    parameter logic [21:0] OBJROM_BASE  = 22'h010000
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_RST,
    input  logic        i_EMU_DLOAD_BUSY,
    input  logic [16:0] i_EMU_MAINCPU_ADDR,
    input  logic        i_EMU_MAINCPU_RQ_n,
    output logic [7:0]  o_EMU_MAINCPU_DATA,
    output logic        o_EMU_MAINCPU_RDY,
    input  logic [16:0] i_EMU_OBJROM_ADDR,
    input  logic        i_EMU_OBJROM_RQ_n,
    output logic [7:0]  o_EMU_OBJROM_DATA,
    output logic        o_EMU_OBJROM_RDY,
    output logic [21:0] o_SDRAM_ADDR,
    output logic        o_SDRAM_RD,
    input  logic [15:0] i_SDRAM_DATA,
    input  logic        i_SDRAM_DVALID
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_CPU = 2'd1,
        FETCH_OBJ = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_obj_q, last_obj_d;
    logic        discard_q, discard_d;
    logic [15:0] fetch_tag_q, fetch_tag_d;
    logic [21:0] sdram_addr_q, sdram_addr_d;
    logic        sdram_rd_q, sdram_rd_d;

    logic [15:0] cpu_word_q, cpu_word_d;
    logic [15:0] cpu_tag_q, cpu_tag_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic [7:0]  cpu_data_q, cpu_data_d;

    logic [15:0] obj_word_q, obj_word_d;
    logic [15:0] obj_tag_q, obj_tag_d;
    logic        obj_valid_q, obj_valid_d;
    logic        obj_rdy_q, obj_rdy_d;
    logic [7:0]  obj_data_q, obj_data_d;

    logic cpu_hit, obj_hit, cpu_pend, obj_pend, grant_cpu, grant_obj;

    always_comb begin
        cpu_hit  = !i_EMU_MAINCPU_RQ_n && cpu_valid_q && !i_EMU_DLOAD_BUSY
                   && (cpu_tag_q == i_EMU_MAINCPU_ADDR[16:1]);
        obj_hit  = !i_EMU_OBJROM_RQ_n && obj_valid_q && !i_EMU_DLOAD_BUSY
                   && (obj_tag_q == i_EMU_OBJROM_ADDR[16:1]);
        cpu_pend = !i_EMU_MAINCPU_RQ_n && !cpu_hit && !i_EMU_DLOAD_BUSY;
        obj_pend = !i_EMU_OBJROM_RQ_n && !obj_hit && !i_EMU_DLOAD_BUSY;

        // On a tie the port that did not win the previous tie goes first.
        grant_cpu = 1'b0;
        grant_obj = 1'b0;
        if (state_q == IDLE) begin
            grant_cpu = cpu_pend && (!obj_pend || last_obj_q);
            grant_obj = obj_pend && (!cpu_pend || !last_obj_q);
        end

        state_d      = state_q;
        last_obj_d   = last_obj_q;
        discard_d    = discard_q;
        fetch_tag_d  = fetch_tag_q;
        sdram_addr_d = sdram_addr_q;
        sdram_rd_d   = sdram_rd_q;
        cpu_word_d   = cpu_word_q;
        cpu_tag_d    = cpu_tag_q;
        cpu_valid_d  = cpu_valid_q;
        obj_word_d   = obj_word_q;
        obj_tag_d    = obj_tag_q;
        obj_valid_d  = obj_valid_q;

        cpu_rdy_d  = cpu_hit;
        cpu_data_d = cpu_hit ? (i_EMU_MAINCPU_ADDR[0] ? cpu_word_q[15:8] : cpu_word_q[7:0])
                             : cpu_data_q;
        obj_rdy_d  = obj_hit;
        obj_data_d = obj_hit ? (i_EMU_OBJROM_ADDR[0] ? obj_word_q[15:8] : obj_word_q[7:0])
                             : obj_data_q;

        // A download poisons any fetch in flight, even if it ends before DVALID.
        if (i_EMU_DLOAD_BUSY) begin
            cpu_valid_d = 1'b0;
            obj_valid_d = 1'b0;
            if (state_q != IDLE) discard_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cpu_pend && obj_pend) last_obj_d = grant_obj;
                if (grant_cpu) begin
                    state_d      = FETCH_CPU;
                    sdram_rd_d   = 1'b1;
                    sdram_addr_d = MAINCPU_BASE + {6'd0, i_EMU_MAINCPU_ADDR[16:1]};
                    fetch_tag_d  = i_EMU_MAINCPU_ADDR[16:1];
                    discard_d    = 1'b0;
                end else if (grant_obj) begin
                    state_d      = FETCH_OBJ;
                    sdram_rd_d   = 1'b1;
                    sdram_addr_d = OBJROM_BASE + {6'd0, i_EMU_OBJROM_ADDR[16:1]};
                    fetch_tag_d  = i_EMU_OBJROM_ADDR[16:1];
                    discard_d    = 1'b0;
                end
            end
            FETCH_CPU: begin
                if (i_SDRAM_DVALID) begin
                    cpu_word_d  = i_SDRAM_DATA;
                    cpu_tag_d   = fetch_tag_q;
                    cpu_valid_d = !i_EMU_DLOAD_BUSY && !discard_q;
                    sdram_rd_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            FETCH_OBJ: begin
                if (i_SDRAM_DVALID) begin
                    obj_word_d  = i_SDRAM_DATA;
                    obj_tag_d   = fetch_tag_q;
                    obj_valid_d = !i_EMU_DLOAD_BUSY && !discard_q;
                    sdram_rd_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                sdram_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            state_q      <= IDLE;
            last_obj_q   <= 1'b1;
            discard_q    <= 1'b0;
            fetch_tag_q  <= 16'd0;
            sdram_addr_q <= 22'd0;
            sdram_rd_q   <= 1'b0;
            cpu_word_q   <= 16'd0;
            cpu_tag_q    <= 16'd0;
            cpu_valid_q  <= 1'b0;
            cpu_rdy_q    <= 1'b0;
            cpu_data_q   <= 8'd0;
            obj_word_q   <= 16'd0;
            obj_tag_q    <= 16'd0;
            obj_valid_q  <= 1'b0;
            obj_rdy_q    <= 1'b0;
            obj_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_obj_q   <= last_obj_d;
            discard_q    <= discard_d;
            fetch_tag_q  <= fetch_tag_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_rd_q   <= sdram_rd_d;
            cpu_word_q   <= cpu_word_d;
            cpu_tag_q    <= cpu_tag_d;
            cpu_valid_q  <= cpu_valid_d;
            cpu_rdy_q    <= cpu_rdy_d;
            cpu_data_q   <= cpu_data_d;
            obj_word_q   <= obj_word_d;
            obj_tag_q    <= obj_tag_d;
            obj_valid_q  <= obj_valid_d;
            obj_rdy_q    <= obj_rdy_d;
            obj_data_q   <= obj_data_d;
        end
    end

    assign o_EMU_MAINCPU_DATA = cpu_data_q;
    assign o_EMU_MAINCPU_RDY  = cpu_rdy_q;
    assign o_EMU_OBJROM_DATA  = obj_data_q;
    assign o_EMU_OBJROM_RDY   = obj_rdy_q;
    assign o_SDRAM_ADDR       = sdram_addr_q;
    assign o_SDRAM_RD         = sdram_rd_q;

endmodule

// File: doc/psychic5_sdram_arbiter.md
Name: psychic5_sdram_arbiter

Overview:
- Downstream of the top-level SDRAM request outputs. Services the two byte-wide ROM request ports: the main CPU program ROM and the object ROM.
- Each port has a one-word (16-bit) fetch cache. Misses are arbitrated onto a single 16-bit SDRAM read channel; each requester gets its byte back plus a ready flag.
- Sits between the core top and the board SDRAM controller.
- Invalidates its caches during ROM download.

Parameters:
- MAINCPU_BASE, 22'h000000, SDRAM word base address of the main CPU ROM region.
- OBJROM_BASE, 22'h010000, SDRAM word base address of the object ROM region (128 KB = 64 Kwords above CPU ROM).

Ports:
- i_EMU_MCLK  in  1  master clock; all logic on rising edge.
- i_EMU_RST  in  1  synchronous, active-high reset.
- i_EMU_DLOAD_BUSY  in  1  ROM download in progress; blocks grants and invalidates caches.
- i_EMU_MAINCPU_ADDR  in  17  CPU ROM byte address.
- i_EMU_MAINCPU_RQ_n  in  1  CPU request, active low (level).
- o_EMU_MAINCPU_DATA  out  8  CPU ROM byte.
- o_EMU_MAINCPU_RDY  out  1  CPU data valid for the current address.
- i_EMU_OBJROM_ADDR  in  17  OBJ ROM byte address.
- i_EMU_OBJROM_RQ_n  in  1  OBJ request, active low (level).
- o_EMU_OBJROM_DATA  out  8  OBJ ROM byte.
- o_EMU_OBJROM_RDY  out  1  OBJ data valid for the current address.
- o_SDRAM_ADDR  out  22  SDRAM word address.
- o_SDRAM_RD  out  1  read request; held high until data returns.
- i_SDRAM_DATA  in  16  returned word.
- i_SDRAM_DVALID  in  1  one-cycle strobe: i_SDRAM_DATA valid.

Behaviour:
- Reset values:
  - all outputs 0;
  - both cache valid bits 0, both tags 0;
  - FSM in IDLE;
  - last-grant = OBJ, so the CPU wins the first tie.
- Per-port cache: 16-bit word, 16-bit tag = ADDR[16:1], valid bit.
- Hit: RQ_n low && valid && tag == ADDR[16:1] && !DLOAD_BUSY.
- Byte select: ADDR[0]=0 selects word[7:0]; ADDR[0]=1 selects word[15:8].
- RDY and DATA are registered:
  - on a sampled hit, the next cycle gives RDY=1 and DATA=selected byte;
  - otherwise the next cycle gives RDY=0 and DATA holds its last value;
  - hit latency is therefore 1 cycle.
- Pending: RQ_n low && !hit && !DLOAD_BUSY, evaluated every cycle.
- RQ_n high: no pending, RDY=0 next cycle; cache contents retained.
- FSM states: IDLE, FETCH_CPU, FETCH_OBJ.
- IDLE:
  - only CPU pending: go to FETCH_CPU;
  - only OBJ pending: go to FETCH_OBJ;
  - both pending: grant the port opposite last-grant, then update last-grant;
  - on the grant edge: o_SDRAM_RD=1 and o_SDRAM_ADDR = BASE + ADDR[16:1] (22-bit add, wraps modulo 2^22);
  - the tag being fetched is latched at grant.
- FETCH_x:
  - o_SDRAM_RD and o_SDRAM_ADDR held stable;
  - on DVALID: cache word = DATA, tag = latched tag, valid=1, o_SDRAM_RD=0, return to IDLE;
  - the next IDLE cycle can grant again, giving one dead cycle between fetches.
- Miss latency: 1 (grant) + SDRAM latency + 1 (fill) + 1 (registered RDY), measured from RQ_n low.
- Address change during a fetch: the fetch completes and fills with the old tag. The new address then misses and is re-fetched. RDY is never asserted for a stale tag.
- The same port re-requesting the word just filled is a hit; no second fetch.
- DVALID in IDLE: ignored, no cache change.
- DLOAD_BUSY=1:
  - both valid bits cleared every cycle; RDY=0 next cycle;
  - no new grant;
  - an outstanding fetch still waits for DVALID, and its data is discarded (valid stays 0).
- Reset mid-fetch:
  - immediate return to IDLE with o_SDRAM_RD=0 and caches invalid;
  - a DVALID arriving after reset is ignored.
- Simultaneous hit on one port and miss on the other: the hit is served in 1 cycle, independent of the FSM.

Test Plan:
- Reset, then CPU RQ_n low with ADDR=17'h00001 → o_SDRAM_RD=1 and o_SDRAM_ADDR=22'h000000. Return DATA=16'hBEEF with DVALID → CPU RDY=1 and DATA=8'hBE two cycles after DVALID. Change ADDR to 17'h00000 → RDY=1, DATA=8'hEF one cycle later, with no new SDRAM read.
- OBJ ADDR=17'h1FFFF miss → o_SDRAM_ADDR=22'h01FFFF. Return 16'h1234 → OBJ DATA=8'h12.
- CPU and OBJ both miss in the same cycle after reset → CPU granted first, OBJ granted on the cycle after CPU's DVALID plus one. On the next simultaneous miss, OBJ is granted first.
- CPU ADDR changes from 17'h00010 to 17'h00020 mid-fetch → the first fill does not assert RDY. A second read at word 22'h000010 is issued, then RDY=1.
- Both caches valid, pulse i_EMU_DLOAD_BUSY for 1 cycle → both RDY drop. The next requests miss and re-fetch. Assert DLOAD_BUSY during a fetch → DVALID data is discarded and RDY stays 0.
- Assert i_EMU_RST during FETCH_OBJ, then DVALID one cycle later → o_SDRAM_RD=0, all outputs 0, the cache stays invalid, and the FSM is in IDLE.
